// File: rtl/ltssm_timer_bank.sv
// Bank of independent LTSSM timeout timers in the Pclk domain. Each channel latches a
// Gen/PIPE-width scaled interval at Start and runs one-shot or periodic.
module ltssm_timer_bank #(
    parameter int NUM_TIMERS     = 4,
    parameter int CNT_WIDTH      = 32,
    parameter int GEN1_PIPEWIDTH = 8,
    parameter int GEN2_PIPEWIDTH = 8,
    parameter int GEN3_PIPEWIDTH = 8,
    parameter int GEN4_PIPEWIDTH = 8,
    parameter int GEN5_PIPEWIDTH = 8,
    parameter int SIM_SHIFT      = 0
) (
    input  logic                    Pclk,
    input  logic                    Reset,
    input  logic [2:0]              Gen,
    input  logic [NUM_TIMERS-1:0]   Start,
    input  logic [NUM_TIMERS-1:0]   Stop,
    input  logic [NUM_TIMERS-1:0]   Enable,
    input  logic [NUM_TIMERS-1:0]   Periodic,
    input  logic [3*NUM_TIMERS-1:0] IntervalCode,
    output logic [NUM_TIMERS-1:0]   TimeOut,
    output logic [NUM_TIMERS-1:0]   Expire,
    output logic [NUM_TIMERS-1:0]   Active
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [63:0] MAX_COUNT = (64'd1 << CNT_WIDTH) - 64'd1;

    // Narrower PIPE interfaces run Pclk faster, so each halving of width doubles the count.
    function automatic logic [2:0] width_shift(input int pipe_width);
        case (pipe_width)
            32:      return 3'd0;
            16:      return 3'd1;
            default: return 3'd2;
        endcase
    endfunction

    function automatic logic [63:0] base_cycles(input logic [2:0] code);
        logic [63:0] b;
        case (code)
            3'b000: b = 64'd0;
            3'b001: b = 64'd750000;
            3'b010: b = 64'd1500000;
            3'b011: b = 64'd3000000;
            3'b100: b = 64'd125000;
            3'b101: b = 64'd500000;
            3'b110: b = 64'd62500;
            default: b = 64'd6250;
        endcase
        return b >> SIM_SHIFT;
    endfunction

    logic [2:0] gen_shift;
    logic [2:0] pipe_shift;
    logic [2:0] scale_shift;

    always_comb begin
        gen_shift  = 3'd0;
        pipe_shift = width_shift(GEN1_PIPEWIDTH);
        case (Gen)
            3'd2: begin
                gen_shift  = 3'd1;
                pipe_shift = width_shift(GEN2_PIPEWIDTH);
            end
            3'd3: begin
                gen_shift  = 3'd2;
                pipe_shift = width_shift(GEN3_PIPEWIDTH);
            end
            3'd4: begin
                gen_shift  = 3'd3;
                pipe_shift = width_shift(GEN4_PIPEWIDTH);
            end
            3'd5: begin
                gen_shift  = 3'd4;
                pipe_shift = width_shift(GEN5_PIPEWIDTH);
            end
            default: begin
                gen_shift  = 3'd0;
                pipe_shift = width_shift(GEN1_PIPEWIDTH);
            end
        endcase
        scale_shift = gen_shift + pipe_shift;
    end

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_chan
        state_t               state;
        state_t               state_nxt;
        logic [CNT_WIDTH-1:0] tick;
        logic [CNT_WIDTH-1:0] tick_nxt;
        logic [CNT_WIDTH-1:0] interval;
        logic [CNT_WIDTH-1:0] interval_req;
        logic [63:0]          scaled;
        logic                 periodic_q;
        logic                 timeout_q;
        logic                 timeout_nxt;
        logic                 expire_q;
        logic                 expire_nxt;
        logic                 active_q;
        logic                 expired;

        // Saturating the interval keeps the up-counter from ever needing to wrap.
        always_comb begin
            scaled       = base_cycles(IntervalCode[3*i +: 3]) << scale_shift;
            interval_req = (scaled > MAX_COUNT) ? {CNT_WIDTH{1'b1}} : scaled[CNT_WIDTH-1:0];
        end

        assign expired = (tick >= interval);

        always_ff @(posedge Pclk) begin
            if (!Reset) begin
                state      <= IDLE;
                tick       <= '0;
                interval   <= '0;
                periodic_q <= 1'b0;
                timeout_q  <= 1'b0;
                expire_q   <= 1'b0;
                active_q   <= 1'b0;
            end else begin
                state     <= state_nxt;
                tick      <= tick_nxt;
                timeout_q <= timeout_nxt;
                expire_q  <= expire_nxt;
                active_q  <= (state_nxt == RUN);
                if (Start[i]) begin
                    interval   <= interval_req;
                    periodic_q <= Periodic[i];
                end
            end
        end

        // Start outranks Stop, and both outrank an expiry in the same cycle.
        always_comb begin
            state_nxt = state;
            if (Start[i]) begin
                state_nxt = RUN;
            end else if (Stop[i]) begin
                state_nxt = IDLE;
            end else if (state == RUN && expired && !periodic_q) begin
                state_nxt = DONE;
            end
        end

        always_comb begin
            tick_nxt    = tick;
            timeout_nxt = timeout_q;
            expire_nxt  = 1'b0;
            if (Start[i] || Stop[i]) begin
                tick_nxt    = '0;
                timeout_nxt = 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (expired) begin
                            expire_nxt = 1'b1;
                            if (periodic_q) begin
                                tick_nxt = '0;
                            end else begin
                                timeout_nxt = 1'b1;
                            end
                        end else if (Enable[i]) begin
                            tick_nxt = tick + CNT_WIDTH'(1);
                        end
                    end
                    DONE: begin
                        timeout_nxt = 1'b1;
                    end
                    default: begin
                        tick_nxt    = '0;
                        timeout_nxt = 1'b0;
                    end
                endcase
            end
        end

        assign TimeOut[i] = timeout_q;
        assign Expire[i]  = expire_q;
        assign Active[i]  = active_q;
    end

endmodule

// File: tb/tb_ltssm_timer_bank.sv
// Directed and randomized bench for ltssm_timer_bank, checked every cycle against a
// countdown model of the timer rules plus literal latency expectations.
module tb_ltssm_timer_bank;

    localparam int NT = 4;
    localparam int CW = 12;
    localparam int SS = 10;

    logic          pclk;
    logic          reset;
    logic [2:0]    gen;
    logic [NT-1:0] start;
    logic [NT-1:0] stop;
    logic [NT-1:0] enable;
    logic [NT-1:0] periodic;
    logic [3*NT-1:0] interval_code;
    logic [NT-1:0] timeout;
    logic [NT-1:0] expire;
    logic [NT-1:0] active;

    ltssm_timer_bank #(
        .NUM_TIMERS    (NT),
        .CNT_WIDTH     (CW),
        .GEN1_PIPEWIDTH(8),
        .GEN2_PIPEWIDTH(16),
        .GEN3_PIPEWIDTH(16),
        .GEN4_PIPEWIDTH(32),
        .GEN5_PIPEWIDTH(32),
        .SIM_SHIFT     (SS)
    ) dut (
        .Pclk        (pclk),
        .Reset       (reset),
        .Gen         (gen),
        .Start       (start),
        .Stop        (stop),
        .Enable      (enable),
        .Periodic    (periodic),
        .IntervalCode(interval_code),
        .TimeOut     (timeout),
        .Expire      (expire),
        .Active      (active)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    longint base_tab [8] = '{0, 750000, 1500000, 3000000, 125000, 500000, 62500, 6250};
    int     pw_tab   [5] = '{8, 16, 16, 32, 32};

    // Expected interval straight from the base table, Gen and PIPE width.
    function automatic longint model_interval(input int code, input int g_in);
        int     g;
        int     w;
        longint v;
        g = (g_in >= 1 && g_in <= 5) ? g_in - 1 : 0;
        w = (pw_tab[g] == 32) ? 0 : (pw_tab[g] == 16) ? 1 : 2;
        v = (base_tab[code] / (longint'(1) << SS)) * (longint'(1) << (g + w));
        if (v > (longint'(1) << CW) - 1) v = (longint'(1) << CW) - 1;
        return v;
    endfunction

    longint  m_rem [NT];
    longint  m_ivl [NT];
    bit      m_run [NT];
    bit      m_done[NT];
    bit      m_per [NT];
    logic [NT-1:0] exp_timeout;
    logic [NT-1:0] exp_expire;
    logic [NT-1:0] exp_active;

    // Reference: count remaining enabled cycles down; expiry is seen one cycle after zero.
    always @(posedge pclk) begin
        for (int c = 0; c < NT; c++) begin
            bit e;
            e = 1'b0;
            if (!reset) begin
                m_run[c]  = 1'b0;
                m_done[c] = 1'b0;
                m_rem[c]  = 0;
            end else if (start[c]) begin
                m_ivl[c]  = model_interval(int'(interval_code[3*c +: 3]), int'(gen));
                m_rem[c]  = m_ivl[c];
                m_per[c]  = periodic[c];
                m_run[c]  = 1'b1;
                m_done[c] = 1'b0;
            end else if (stop[c]) begin
                m_run[c]  = 1'b0;
                m_done[c] = 1'b0;
            end else if (m_run[c]) begin
                if (m_rem[c] == 0) begin
                    e = 1'b1;
                    if (m_per[c]) begin
                        m_rem[c] = m_ivl[c];
                    end else begin
                        m_run[c]  = 1'b0;
                        m_done[c] = 1'b1;
                    end
                end else if (enable[c]) begin
                    m_rem[c] = m_rem[c] - 1;
                end
            end
            exp_expire[c]  = e;
            exp_timeout[c] = m_done[c];
            exp_active[c]  = m_run[c];
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    always @(posedge pclk) begin
        #1;
        if (check_en) begin
            check_output("timeout", 64'(timeout), 64'(exp_timeout));
            check_output("expire",  64'(expire),  64'(exp_expire));
            check_output("active",  64'(active),  64'(exp_active));
        end
    end

    task automatic next_cycle();
        @(posedge pclk);
        #2;
    endtask

    task automatic start_ch(input int ch, input int code, input bit per);
        start[ch] = 1'b1;
        interval_code[3*ch +: 3] = 3'(code);
        periodic[ch] = per;
        next_cycle();
        start[ch] = 1'b0;
    endtask

    // Counts cycles from the Start edge until TimeOut (sel=0) or Expire (sel=1) is seen.
    task automatic run_until(input string name, input int ch, input bit sel, input bit toggle,
                             input int gen_change_at, input int limit,
                             output int cycles, output int pulses);
        bit hit;
        cycles = 0;
        pulses = 0;
        hit    = 1'b0;
        while (!hit && cycles < limit) begin
            @(posedge pclk);
            #1;
            cycles++;
            if (expire[ch]) pulses++;
            hit = sel ? expire[ch] : timeout[ch];
            #1;
            if (toggle) enable[ch] = ~enable[ch];
            if (cycles == gen_change_at) gen = 3'd5;
        end
        if (!hit) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_wait: no event within %0d cycles", name, limit);
        end
    endtask

    task automatic apply_stimulus(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            for (int c = 0; c < NT; c++) begin
                start[c]    = ($urandom_range(0, 299) == 0);
                stop[c]     = ($urandom_range(0, 799) == 0);
                enable[c]   = ($urandom_range(0, 3) != 0);
                periodic[c] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 0)
                    interval_code[3*c +: 3] = 3'($urandom_range(0, 7));
                else
                    interval_code[3*c +: 3] = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'b000;
            end
            if ($urandom_range(0, 99) == 0) gen = 3'($urandom_range(0, 7));
            reset = ($urandom_range(0, 3999) != 0);
            next_cycle();
        end
        start = '0;
        stop  = '0;
        reset = 1'b1;
    endtask

    int cyc;
    int pul;
    int cnt;

    initial begin
        reset         = 1'b0;
        gen           = 3'd1;
        start         = '0;
        stop          = '0;
        enable        = '1;
        periodic      = '0;
        interval_code = '0;
        repeat (3) next_cycle();
        check_en = 1'b1;
        check_output("reset_outputs", 64'({timeout, expire, active}), 64'd0);
        reset = 1'b1;
        next_cycle();

        $display("[TB] one-shot Gen1 w8 code 001");
        start_ch(0, 1, 1'b0);
        run_until("oneshot", 0, 1'b0, 1'b0, -1, 5000, cyc, pul);
        check_output("oneshot_latency", 64'(cyc), 64'd2929);
        check_output("oneshot_pulses", 64'(pul), 64'd1);
        next_cycle();
        check_output("oneshot_active_fall", 64'(active[0]), 64'd0);
        check_output("oneshot_timeout_held", 64'(timeout[0]), 64'd1);

        $display("[TB] Gen3 w16 code 100, Enable toggling, Gen change mid-run");
        gen = 3'd3;
        start_ch(1, 4, 1'b0);
        enable[1] = 1'b1;
        run_until("toggle", 1, 1'b0, 1'b1, 300, 5000, cyc, pul);
        check_output("toggle_latency", 64'(cyc), 64'd1952);
        enable[1] = 1'b1;
        gen = 3'd1;

        $display("[TB] periodic code 000");
        start_ch(2, 0, 1'b1);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            if (expire[2]) cnt++;
        end
        check_output("periodic0_pulses", 64'(cnt), 64'd10);
        check_output("periodic0_timeout", 64'(timeout[2]), 64'd0);
        stop[2] = 1'b1;
        next_cycle();
        stop[2] = 1'b0;
        check_output("periodic0_stop", 64'({active[2], expire[2]}), 64'd0);

        $display("[TB] periodic code 111 spacing");
        start_ch(2, 7, 1'b1);
        run_until("period_first", 2, 1'b1, 1'b0, -1, 200, cyc, pul);
        check_output("period_first", 64'(cyc), 64'd25);
        run_until("period_next", 2, 1'b1, 1'b0, -1, 200, cyc, pul);
        check_output("period_spacing", 64'(cyc), 64'd25);
        check_output("period_timeout", 64'(timeout[2]), 64'd0);
        stop[2] = 1'b1;
        next_cycle();
        stop[2] = 1'b0;

        $display("[TB] Start and Stop together restarts");
        start_ch(3, 6, 1'b0);
        repeat (100) next_cycle();
        start[3] = 1'b1;
        stop[3]  = 1'b1;
        next_cycle();
        start[3] = 1'b0;
        stop[3]  = 1'b0;
        check_output("startstop_active", 64'(active[3]), 64'd1);
        run_until("startstop", 3, 1'b0, 1'b0, -1, 1000, cyc, pul);
        check_output("startstop_latency", 64'(cyc), 64'd245);

        $display("[TB] Start while DONE");
        start_ch(3, 6, 1'b0);
        check_output("restart_timeout", 64'(timeout[3]), 64'd0);
        check_output("restart_active", 64'(active[3]), 64'd1);
        stop[3] = 1'b1;
        next_cycle();
        stop[3] = 1'b0;

        $display("[TB] Stop mid-count");
        start_ch(0, 7, 1'b0);
        repeat (10) next_cycle();
        stop[0] = 1'b1;
        next_cycle();
        stop[0] = 1'b0;
        check_output("stop_active", 64'(active[0]), 64'd0);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            next_cycle();
            if (expire[0]) cnt++;
        end
        check_output("stop_no_expire", 64'(cnt), 64'd0);

        $display("[TB] Reset mid-count on all channels");
        start = '1;
        interval_code = {4{3'b010}};
        next_cycle();
        start = '0;
        repeat (50) next_cycle();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        check_output("midreset_outputs", 64'({timeout, expire, active}), 64'd0);
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            next_cycle();
            if (expire != '0) cnt++;
        end
        check_output("midreset_no_expire", 64'(cnt), 64'd0);

        $display("[TB] saturated interval");
        gen = 3'd5;
        start_ch(1, 3, 1'b0);
        run_until("saturate", 1, 1'b0, 1'b0, -1, 6000, cyc, pul);
        check_output("saturate_latency", 64'(cyc), 64'd4096);
        gen = 3'd1;
        stop = '1;
        next_cycle();
        stop = '0;

        $display("[TB] randomized run");
        apply_stimulus(25000);
        repeat (5) next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
